// File: rtl/vga_pkg.sv
// Shared VGA types: resolutions, fill-engine states, palette
// and active-area lookups.
package vga_pkg;

    typedef enum logic {
        VGA_RES_800_600   = 1'b0,
        VGA_RES_1280_1024 = 1'b1
    } vga_resolution_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } vga_fill_state_e;

    typedef enum logic [1:0] {
        BLACK = 2'd0,
        WHITE = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } vga_color_e;

    localparam int ACTIVE_W = 12;

    function automatic logic [ACTIVE_W-1:0] vga_h_active(
        input vga_resolution_e res
    );
        return (res == VGA_RES_1280_1024) ? 12'd1280 : 12'd800;
    endfunction

    function automatic logic [ACTIVE_W-1:0] vga_v_active(
        input vga_resolution_e res
    );
        return (res == VGA_RES_1280_1024) ? 12'd1024 : 12'd600;
    endfunction

endpackage

// File: rtl/vga_fill_clip.sv
// Clips a fill rectangle to the active area; one bit wider than the
// coordinates so x0+w never wraps.
module vga_fill_clip
    import vga_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [ADDR_W-1:0] x0,
    input  logic [ADDR_W-1:0] y0,
    input  logic [ADDR_W-1:0] w,
    input  logic [ADDR_W-1:0] h,
    input  vga_resolution_e   resolution,
    output logic [ADDR_W:0]   x_end,
    output logic [ADDR_W:0]   y_end,
    output logic              empty
);

    logic [ADDR_W:0] h_act;
    logic [ADDR_W:0] v_act;
    logic [ADDR_W:0] x_sum;
    logic [ADDR_W:0] y_sum;

    always_comb begin
        h_act = (ADDR_W+1)'(vga_h_active(resolution));
        v_act = (ADDR_W+1)'(vga_v_active(resolution));
        x_sum = {1'b0, x0} + {1'b0, w};
        y_sum = {1'b0, y0} + {1'b0, h};
        x_end = (x_sum < h_act) ? x_sum : h_act;
        y_end = (y_sum < v_act) ? y_sum : v_act;
        empty = (w == '0) || (h == '0) ||
                ({1'b0, x0} >= h_act) || ({1'b0, y0} >= v_act);
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill drawing engine: one clipped pixel write per cycle,
// row-major, with write back-pressure and abort.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int COLOR_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  vga_resolution_e    resolution_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADDR_W-1:0]  cmd_x0_i,
    input  logic [ADDR_W-1:0]  cmd_y0_i,
    input  logic [ADDR_W-1:0]  cmd_w_i,
    input  logic [ADDR_W-1:0]  cmd_h_i,
    input  logic [COLOR_W-1:0] cmd_color_i,
    input  logic               abort_i,
    output logic [ADDR_W-1:0]  addr_x_o,
    output logic [ADDR_W-1:0]  addr_y_o,
    output logic [COLOR_W-1:0] color_o,
    output logic               we_o,
    input  logic               wr_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    vga_fill_state_e state;
    logic [ADDR_W-1:0] x0_q;
    logic [ADDR_W:0]   x_end_q;
    logic [ADDR_W:0]   y_end_q;
    logic [ADDR_W:0]   x_end;
    logic [ADDR_W:0]   y_end;
    logic              empty;
    logic              wr_fire;
    logic              x_wrap;
    logic              y_last;

    vga_fill_clip #(
        .ADDR_W(ADDR_W)
    ) u_clip (
        .x0        (cmd_x0_i),
        .y0        (cmd_y0_i),
        .w         (cmd_w_i),
        .h         (cmd_h_i),
        .resolution(resolution_i),
        .x_end     (x_end),
        .y_end     (y_end),
        .empty     (empty)
    );

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign wr_fire     = we_o && wr_ready_i;
    assign x_wrap      = ({1'b0, addr_x_o} + {1'b0, ONE}) == x_end_q;
    assign y_last      = ({1'b0, addr_y_o} + {1'b0, ONE}) == y_end_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            we_o     <= 1'b0;
            done_o   <= 1'b0;
            addr_x_o <= '0;
            addr_y_o <= '0;
            color_o  <= '0;
            x0_q     <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        color_o <= cmd_color_i;
                        x0_q    <= cmd_x0_i;
                        x_end_q <= x_end;
                        y_end_q <= y_end;
                        if (empty) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state    <= FILL;
                            we_o     <= 1'b1;
                            addr_x_o <= cmd_x0_i;
                            addr_y_o <= cmd_y0_i;
                        end
                    end
                end
                FILL: begin
                    if (wr_fire) begin
                        if (x_wrap) begin
                            addr_x_o <= x0_q;
                            addr_y_o <= addr_y_o + ONE;
                        end else begin
                            addr_x_o <= addr_x_o + ONE;
                        end
                    end
                    // a write accepted alongside abort still counts
                    if (abort_i || (wr_fire && x_wrap && y_last)) begin
                        state  <= DONE;
                        we_o   <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: vector table plus scoreboard of expected
// pixel writes, with stall, abort and reset sequences.
module tb_vga_rect_fill;
    import vga_pkg::*;

    localparam int ADDR_W  = 11;
    localparam int COLOR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  x;
        logic [ADDR_W-1:0]  y;
        logic [COLOR_W-1:0] c;
    } pix_t;

    typedef struct {
        vga_resolution_e res;
        int x0;
        int y0;
        int w;
        int h;
        int c;
        int exp_n;
    } vec_t;

    logic               clk;
    logic               rst;
    vga_resolution_e    resolution;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_x0;
    logic [ADDR_W-1:0]  cmd_y0;
    logic [ADDR_W-1:0]  cmd_w;
    logic [ADDR_W-1:0]  cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               abort;
    logic [ADDR_W-1:0]  addr_x;
    logic [ADDR_W-1:0]  addr_y;
    logic [COLOR_W-1:0] color;
    logic               we;
    logic               wr_ready;
    logic               busy;
    logic               done;

    pix_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   n_wr;
    int   first_wr;
    int   last_wr;

    vga_rect_fill #(
        .ADDR_W (ADDR_W),
        .COLOR_W(COLOR_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .resolution_i(resolution),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_x0_i    (cmd_x0),
        .cmd_y0_i    (cmd_y0),
        .cmd_w_i     (cmd_w),
        .cmd_h_i     (cmd_h),
        .cmd_color_i (cmd_color),
        .abort_i     (abort),
        .addr_x_o    (addr_x),
        .addr_y_o    (addr_y),
        .color_o     (color),
        .we_o        (we),
        .wr_ready_i  (wr_ready),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted write must match the queue head.
    always @(negedge clk) begin
        pix_t e;
        if (!rst && we && wr_ready) begin
            if (n_wr == 0) first_wr = cyc;
            n_wr++;
            last_wr = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra write: got (%0d,%0d) c=%0d, expected none",
                         addr_x, addr_y, color);
            end else begin
                e = exp_q.pop_front();
                if (addr_x !== e.x || addr_y !== e.y || color !== e.c) begin
                    errors++;
                    $display("FAIL write: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d",
                             addr_x, addr_y, color, e.x, e.y, e.c);
                end
            end
        end
    end

    function automatic void model_push(input vec_t v);
        int ha, va, xe, ye;
        pix_t p;
        ha = (v.res == VGA_RES_1280_1024) ? 1280 : 800;
        va = (v.res == VGA_RES_1280_1024) ? 1024 : 600;
        xe = (v.x0 + v.w < ha) ? v.x0 + v.w : ha;
        ye = (v.y0 + v.h < va) ? v.y0 + v.h : va;
        for (int y = v.y0; y < ye; y++) begin
            for (int x = v.x0; x < xe; x++) begin
                p.x = ADDR_W'(x);
                p.y = ADDR_W'(y);
                p.c = COLOR_W'(v.c);
                exp_q.push_back(p);
            end
        end
    endfunction

    task automatic send(input vec_t v, input bit do_push, output int acc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL cmd_ready timeout: got 0, expected 1");
        end
        resolution = v.res;
        cmd_x0     = ADDR_W'(v.x0);
        cmd_y0     = ADDR_W'(v.y0);
        cmd_w      = ADDR_W'(v.w);
        cmd_h      = ADDR_W'(v.h);
        cmd_color  = COLOR_W'(v.c);
        cmd_valid  = 1'b1;
        n_wr       = 0;
        if (do_push) model_push(v);
        @(posedge clk);
        #1;
        acc        = cyc;
        cmd_valid  = 1'b0;
        // flip resolution to show it was latched at accept
        resolution = (v.res == VGA_RES_800_600) ? VGA_RES_1280_1024
                                                : VGA_RES_800_600;
    endtask

    task automatic wait_done(output int dc);
        bit found;
        found = 1'b0;
        dc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                found = 1'b1;
                break;
            end
        end
        chk("done seen", found, 1);
        @(negedge clk);
        chk("done one cycle", done, 0);
        chk("ready after done", cmd_ready, 1);
    endtask

    vec_t vecs[9];

    initial begin
        int acc, dc;
        checks     = 0;
        errors     = 0;
        n_wr       = 0;
        first_wr   = 0;
        last_wr    = 0;
        rst        = 1'b1;
        resolution = VGA_RES_800_600;
        cmd_valid  = 1'b1;
        cmd_x0     = '0;
        cmd_y0     = '0;
        cmd_w      = 11'd4;
        cmd_h      = 11'd4;
        cmd_color  = 2'd3;
        abort      = 1'b0;
        wr_ready   = 1'b1;

        vecs[0] = '{VGA_RES_800_600,   10,   20,   3,  2, 2,  6};
        vecs[1] = '{VGA_RES_800_600,   798,  599,  5,  4, 1,  2};
        vecs[2] = '{VGA_RES_1280_1024, 1279, 0,    2,  3, 3,  3};
        vecs[3] = '{VGA_RES_800_600,   0,    0,    0,  5, 1,  0};
        vecs[4] = '{VGA_RES_800_600,   5,    5,    4,  0, 1,  0};
        vecs[5] = '{VGA_RES_800_600,   800,  0,    4,  4, 2,  0};
        vecs[6] = '{VGA_RES_1280_1024, 1000, 1020, 3, 10, 1, 12};
        vecs[7] = '{VGA_RES_800_600,   2047, 599, 2047, 2047, 3, 0};
        vecs[8] = '{VGA_RES_1280_1024, 0,    600,  2,  2, 2,  4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst we", we, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", cmd_ready, 1);
        chk("rst done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post-rst busy", busy, 0);
        chk("post-rst addr", {addr_x, addr_y}, 0);
        chk("post-rst color", color, 0);

        abort = 1'b1;
        @(negedge clk);
        chk("idle abort busy", busy, 0);
        chk("idle abort done", done, 0);
        abort = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send(vecs[i], 1'b1, acc);
            wait_done(dc);
            chk($sformatf("v%0d count", i), n_wr, vecs[i].exp_n);
            chk($sformatf("v%0d queue", i), exp_q.size(), 0);
            if (vecs[i].exp_n == 0) begin
                chk($sformatf("v%0d empty done", i), dc, acc);
            end else begin
                chk($sformatf("v%0d first wr", i), first_wr, acc);
                chk($sformatf("v%0d back-to-back", i),
                    last_wr - first_wr, vecs[i].exp_n - 1);
                chk($sformatf("v%0d done after last", i), dc, last_wr + 1);
            end
        end

        // back-pressure: stall 3 cycles while (1,0) is presented
        begin
            vec_t v;
            v = '{VGA_RES_800_600, 0, 0, 4, 1, 3, 4};
            fork
                begin
                    send(v, 1'b1, acc);
                    wait_done(dc);
                end
                begin
                    bit seen;
                    seen = 1'b0;
                    for (int i = 0; i < 60; i++) begin
                        @(negedge clk);
                        if (we && addr_x == 0 && addr_y == 0) begin
                            seen = 1'b1;
                            break;
                        end
                    end
                    chk("stall start", seen, 1);
                    @(posedge clk);
                    #1;
                    wr_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("stall we", we, 1);
                        chk("stall addr", {addr_x, addr_y}, {11'd1, 11'd0});
                        chk("stall color", color, 3);
                        @(posedge clk);
                    end
                    #1;
                    wr_ready = 1'b1;
                end
            join
            chk("stall count", n_wr, 4);
            chk("stall queue", exp_q.size(), 0);
            chk("stall done", dc, last_wr + 1);
        end

        // abort during the 3rd write of a 10-pixel fill
        begin
            vec_t v;
            pix_t p;
            v = '{VGA_RES_800_600, 0, 0, 10, 1, 1, 3};
            for (int i = 0; i < 3; i++) begin
                p.x = ADDR_W'(i);
                p.y = '0;
                p.c = 2'd1;
                exp_q.push_back(p);
            end
            send(v, 1'b0, acc);
            @(posedge clk);
            @(posedge clk);
            #1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            wait_done(dc);
            chk("abort count", n_wr, 3);
            chk("abort queue", exp_q.size(), 0);
            chk("abort done", dc, last_wr + 1);
        end

        // reset in the middle of a fill
        begin
            vec_t v;
            pix_t p;
            bit saw_done;
            v = '{VGA_RES_800_600, 0, 0, 10, 1, 2, 2};
            for (int i = 0; i < 2; i++) begin
                p.x = ADDR_W'(i);
                p.y = '0;
                p.c = 2'd2;
                exp_q.push_back(p);
            end
            send(v, 1'b0, acc);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("rst mid we", we, 0);
            chk("rst mid done", done, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            saw_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            chk("rst mid no done", saw_done, 0);
            chk("rst mid ready", cmd_ready, 1);
            chk("rst mid busy", busy, 0);
            chk("rst mid count", n_wr, 2);
            chk("rst mid queue", exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Drawing engine that writes the frame buffer consumed by the VGA scan-out path. It is the writer side of the `addr_x`/`addr_y`/`color`/`we` pixel-write interface.
- Accepts one rectangle-fill command per handshake.
- Clips the rectangle to the active area of the selected resolution.
- Emits one pixel write per cycle in row-major order, with back-pressure from the buffer side.

Parameters:
- ADDR_W, 11, width of pixel coordinates and sizes.
- COLOR_W, 2, width of the palette index (BLACK=0, WHITE=1, BLUE=2, GREEN=3).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- resolution_i  in  vga_resolution_e  active resolution; sampled at command accept.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  engine can accept a command (high only in IDLE).
- cmd_x0_i  in  ADDR_W  left column.
- cmd_y0_i  in  ADDR_W  top row.
- cmd_w_i  in  ADDR_W  width in pixels.
- cmd_h_i  in  ADDR_W  height in pixels.
- cmd_color_i  in  COLOR_W  fill colour.
- abort_i  in  1  terminate the current fill.
- addr_x_o  out  ADDR_W  write column.
- addr_y_o  out  ADDR_W  write row.
- color_o  out  COLOR_W  write colour.
- we_o  out  1  write request.
- wr_ready_i  in  1  buffer accepts the write this cycle.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock, clk_i; synchronous active-high reset, rst_i.
- Reset values while rst_i is high, and on the first cycle after it falls:
  - state = IDLE.
  - we_o = 0, done_o = 0, busy_o = 0.
  - addr_x_o = 0, addr_y_o = 0, color_o = 0.
  - cmd_ready_o = 1 (decoded from state), but no command is accepted while rst_i is high.
- States: IDLE, FILL, DONE.
- IDLE:
  - A command is accepted on cmd_valid_i & cmd_ready_o.
  - On accept, latch colour and resolution, and compute clipped bounds:
    - x_end = min(x0 + w, H_ACTIVE)
    - y_end = min(y0 + h, V_ACTIVE)
    - Arithmetic is ADDR_W+1 bits unsigned, so there is no wrap on overflow.
    - H_ACTIVE/V_ACTIVE are 800/600 for VGA_RES_800_600 and 1280/1024 for VGA_RES_1280_1024.
  - Empty rectangle (w=0, h=0, x0 >= H_ACTIVE or y0 >= V_ACTIVE): go to DONE and issue no writes.
  - Otherwise go to FILL with addr_x_o = x0, addr_y_o = y0, we_o = 1.
- FILL:
  - Accept at cycle N gives the first we_o at N+1.
  - we_o, addr and colour are held stable until we_o & wr_ready_i.
  - On that handshake the position advances: x+1. When x+1 == x_end, x returns to x0 and y advances by 1.
  - Acceptance of the last pixel (x_end-1, y_end-1) moves to DONE with we_o = 0 in the same update.
  - Throughput is 1 pixel per cycle while wr_ready_i = 1.
  - No pixel is skipped or duplicated.
- abort_i in FILL:
  - Next state DONE, we_o = 0 next cycle.
  - A write handshaked in the same cycle as abort_i counts as done; no further writes follow.
  - abort_i in IDLE or DONE is ignored.
- DONE:
  - done_o = 1 for exactly one cycle, then IDLE.
  - For an empty command accepted at cycle N, done_o is high at N+1 and cmd_ready_o is high again at N+2.
- Changes of resolution_i after accept have no effect on the running fill.
- rst_i mid-FILL: we_o drops on the next cycle, no done_o pulse, state IDLE.
- busy_o = (state != IDLE), registered consistently with state.

Decomposition:
- vga_pkg additions:
  - vga_fill_state_e (IDLE/FILL/DONE).
  - vga_color_e palette enum (BLACK, WHITE, BLUE, GREEN).
  - Functions vga_h_active(vga_resolution_e) and vga_v_active(vga_resolution_e).
  - Reuse the existing vga_resolution_e.
- One combinational sub-module, vga_fill_clip: takes x0/y0/w/h and resolution, outputs x_end, y_end and empty.

Test Plan:
- 800x600, x0=10, y0=20, w=3, h=2, colour=2, wr_ready_i=1:
  - we_o high 6 consecutive cycles with (10,20), (11,20), (12,20), (10,21), (11,21), (12,21).
  - color_o=2 throughout; done_o pulses the cycle after the last write.
- Clipping, 800x600, x0=798, y0=599, w=5, h=4: exactly two writes, (798,599) then (799,599), then done_o.
- 1280x1024, x0=1279, y0=0, w=2, h=3: writes (1279,0), (1279,1), (1279,2).
- w=0 accepted at cycle N: we_o never high, done_o=1 at N+1, cmd_ready_o=1 at N+2.
- Back-pressure, 800x600, x0=0, y0=0, w=4, h=1: wr_ready_i low for 3 cycles while (1,0) is presented.
  - addr and colour stay stable during the stall.
  - Write order is exactly (0,0), (1,0), (2,0), (3,0).
- Abort and reset mid-fill:
  - abort_i during the 3rd write of a 10-pixel fill (wr_ready_i=1) gives 3 writes, done_o one cycle later, then IDLE.
  - rst_i mid-fill gives we_o=0 next cycle, no done_o, and cmd_ready_o=1 after release.
